// File: rtl/tiny_eth_pkg.sv
// Shared types and constants for the tiny Ethernet receive path.
// CRC constants are used only when TINY_ETH_RX_CRC_EN is defined.
package tiny_eth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } rx_state_t;

  typedef struct packed {
    logic fcs;
    logic rxer;
    logic dribble;
    logic too_long;
    logic runt;
  } rx_status_t;

  localparam logic [3:0] ETH_PRE_NIBBLE = 4'h5;
  localparam logic [3:0] ETH_SFD_NIBBLE = 4'hD;

  localparam logic [47:0] ETH_BCAST =
    48'hFFFF_FFFF_FFFF;

  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  function automatic logic [31:0] bit_rev32(
    input logic [31:0] v
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/tiny_eth_crc32.sv
// Reflected CRC-32 over one byte per enabled cycle.
// nxt is the register value after absorbing the current byte.
module tiny_eth_crc32
  import tiny_eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [31:0] crc,
  output logic [31:0] nxt
);

  localparam logic [31:0] RPOLY =
    bit_rev32(CRC_POLY);

  logic [31:0] acc;

  always_comb begin
    acc = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      if (acc[0]) acc = (acc >> 1) ^ RPOLY;
      else        acc = acc >> 1;
    end
    nxt = acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= nxt;
    end
  end

endmodule

// File: rtl/tiny_eth_rx_ctrl.sv
// PHY nibble to byte-stream receive controller with framing and status.
// Define TINY_ETH_RX_CRC_EN to enable FCS checking.
module tiny_eth_rx_ctrl
  import tiny_eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int PRE_MIN = 2
) (
  input  logic        rx_clk,
  input  logic        rst,
  input  logic        rx_en,
  input  logic        rx_er,
  input  logic [3:0]  rx_data,
  input  logic        cfg_enable,
  input  logic        cfg_promisc,
  input  logic [47:0] cfg_mac_addr,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic [4:0]  out_status,
  output logic        out_drop,
  output logic        stat_ok,
  output logic        stat_err,
  output logic        busy
);

  localparam int CW = $clog2(MAX_LEN + 2);
  localparam logic [CW-1:0] CNT_LONG =
    CW'(MAX_LEN + 1);
  localparam logic [CW-1:0] CNT_MIN = CW'(MIN_LEN);
  localparam logic [CW-1:0] CNT_DA = CW'(5);

  rx_state_t     state;
  logic [3:0]    pre_cnt;
  logic [3:0]    low_nib;
  logic          nib_hi;
  logic          hold_vld;
  logic          first;
  logic          rxer;
  logic          drop;
  logic [7:0]    hold;
  logic [CW-1:0] cnt;
  logic [39:0]   da;

  logic [7:0]    new_byte;
  logic [CW-1:0] cnt_inc;
  logic          byte_done;
  logic [47:0]   da_full;
  logic          da_hit;
  logic          fcs_bad;
  logic          fcs_bad_long;
  rx_status_t    st_end;
  rx_status_t    st_long;

  assign new_byte  = {rx_data, low_nib};
  assign cnt_inc   = (cnt == '1) ? cnt
                   : cnt + CW'(1);
  assign byte_done = (state == DATA) && rx_en
                   && nib_hi;
  assign da_full   = {da, new_byte};
  assign da_hit    = (da_full == cfg_mac_addr)
                   || (da_full == ETH_BCAST)
                   || da_full[40]
                   || cfg_promisc;
  assign busy      = (state != IDLE);

`ifdef TINY_ETH_RX_CRC_EN
  logic [31:0] crc;
  logic [31:0] crc_nxt;

  tiny_eth_crc32 u_crc (
    .clk    (rx_clk),
    .rst_n  (rst),
    .clear  (state == PRE),
    .enable (byte_done),
    .data   (new_byte),
    .crc    (crc),
    .nxt    (crc_nxt)
  );

  assign fcs_bad =
    bit_rev32(crc) != CRC_RESIDUE;
  assign fcs_bad_long =
    bit_rev32(crc_nxt) != CRC_RESIDUE;
`else
  assign fcs_bad      = 1'b0;
  assign fcs_bad_long = 1'b0;
`endif

  // Status for a normal end vs. the LONG cut-off edge
  always_comb begin
    st_end          = '0;
    st_end.fcs      = fcs_bad;
    st_end.rxer     = rxer;
    st_end.dribble  = nib_hi;
    st_end.runt     = cnt < CNT_MIN;
    st_long          = '0;
    st_long.fcs      = fcs_bad_long;
    st_long.rxer     = rxer | rx_er;
    st_long.too_long = 1'b1;
  end

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      low_nib    <= '0;
      nib_hi     <= 1'b0;
      hold_vld   <= 1'b0;
      first      <= 1'b0;
      rxer       <= 1'b0;
      drop       <= 1'b0;
      hold       <= '0;
      cnt        <= '0;
      da         <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_status <= '0;
      out_drop   <= 1'b0;
      stat_ok    <= 1'b0;
      stat_err   <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_status <= '0;
      out_drop   <= 1'b0;
      stat_ok    <= 1'b0;
      stat_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_en && cfg_enable &&
              rx_data == ETH_PRE_NIBBLE) begin
            state   <= PRE;
            pre_cnt <= 4'd1;
          end
        end
        PRE: begin
          if (rx_en &&
              rx_data == ETH_PRE_NIBBLE) begin
            if (pre_cnt != 4'hF)
              pre_cnt <= pre_cnt + 4'd1;
          end else if (rx_en &&
              rx_data == ETH_SFD_NIBBLE &&
              pre_cnt >= 4'(PRE_MIN)) begin
            state    <= DATA;
            nib_hi   <= 1'b0;
            hold_vld <= 1'b0;
            first    <= 1'b1;
            rxer     <= 1'b0;
            drop     <= 1'b0;
            cnt      <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (!rx_en) begin
            state      <= IDLE;
            out_valid  <= hold_vld;
            out_data   <= hold;
            out_sof    <= hold_vld & first;
            out_eof    <= hold_vld;
            out_drop   <= hold_vld & drop;
            out_status <= st_end;
            stat_ok    <= (st_end == '0) && !drop;
            stat_err   <= (st_end != '0);
          end else begin
            rxer   <= rxer | rx_er;
            nib_hi <= !nib_hi;
            if (!nib_hi) begin
              low_nib <= rx_data;
            end else begin
              cnt      <= cnt_inc;
              hold     <= new_byte;
              hold_vld <= 1'b1;
              if (cnt < CNT_DA)
                da <= {da[31:0], new_byte};
              if (cnt == CNT_DA)
                drop <= !da_hit;
              if (hold_vld) begin
                out_valid <= 1'b1;
                out_data  <= hold;
                out_sof   <= first;
                first     <= 1'b0;
              end
              // Held byte closes the frame as LONG
              if (cnt_inc == CNT_LONG) begin
                state      <= DROP;
                out_eof    <= 1'b1;
                out_status <= st_long;
                out_drop   <= drop;
                stat_err   <= 1'b1;
              end
            end
          end
        end
        DROP: begin
          if (!rx_en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
